fetch_block_unpacker: RTL and testbench



---
 rtl/fetch_block_unpacker.sv | 93 +++++++++
 tb/tb_fetch_block_unpacker.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_block_unpacker.sv
// Fetch block unpacker: takes one fetch block with a slot-valid mask and
// emits the valid slots one per cycle, lowest slot first, toward the fifo.
module fetch_block_unpacker #(
    parameter int N_SLOTS     = 4,
    parameter int ENTRY_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           blk_valid,
    output logic                           blk_ready,
    input  logic [N_SLOTS*ENTRY_WIDTH-1:0] blk_data,
    input  logic [N_SLOTS-1:0]             blk_mask,
    output logic                           enq_valid,
    input  logic                           enq_ready,
    output logic [ENTRY_WIDTH-1:0]         enq_data,
    output logic                           enq_last
);

    typedef enum logic {
        EMPTY,
        DRAIN
    } state_t;

    localparam logic [N_SLOTS-1:0] ONE = N_SLOTS'(1);

    state_t                         state;
    state_t                         state_nx;
    logic [N_SLOTS*ENTRY_WIDTH-1:0] held_data;
    logic [N_SLOTS-1:0]             rem_mask;
    logic [N_SLOTS-1:0]             rem_nx;
    logic [N_SLOTS-1:0]             low_bit;
    logic                           enq_fire;
    logic                           blk_fire;

    // Isolate the lowest pending slot; a single pending bit marks the last beat.
    assign low_bit  = rem_mask & (~rem_mask + ONE);
    assign enq_last = (rem_mask != '0) && ((rem_mask & (rem_mask - ONE)) == '0);

    // Select the held instruction at the lowest pending slot.
    always_comb begin
        enq_data = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (low_bit[i]) begin
                enq_data = held_data[i*ENTRY_WIDTH +: ENTRY_WIDTH];
            end
        end
    end

    // Handshake outputs and next mask/state; flush beats a new block beats a clear.
    always_comb begin
        enq_valid = 1'b0;
        blk_ready = 1'b0;
        enq_fire  = 1'b0;
        blk_fire  = 1'b0;
        rem_nx    = rem_mask;
        state_nx  = state;

        enq_valid = ~rst & ~flush & (state == DRAIN);
        enq_fire  = enq_valid & enq_ready;
        blk_ready = ~rst & ~flush & ((state == EMPTY) | (enq_fire & enq_last));
        blk_fire  = blk_valid & blk_ready;

        if (flush) begin
            rem_nx = '0;
        end else if (blk_fire) begin
            rem_nx = blk_mask;
        end else if (enq_fire) begin
            rem_nx = rem_mask & ~low_bit;
        end

        state_nx = (rem_nx != '0) ? DRAIN : EMPTY;
    end

    // State register; reset drops any pending slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= EMPTY;
            rem_mask <= '0;
        end else begin
            state    <= state_nx;
            rem_mask <= rem_nx;
        end
    end

    // Capture the block payload on acceptance.
    always_ff @(posedge clk) begin
        if (blk_fire) begin
            held_data <= blk_data;
        end
    end

endmodule

// File: tb/tb_fetch_block_unpacker.sv
// Scoreboard bench for fetch_block_unpacker: a driver pushes expected beats
// per accepted block; a monitor checks every cycle and pops on each fire.
module tb_fetch_block_unpacker;

    localparam int N  = 4;
    localparam int W  = 32;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic           blk_valid;
    logic           blk_ready;
    logic [N*W-1:0] blk_data;
    logic [N-1:0]   blk_mask;
    logic           enq_valid;
    logic           enq_ready;
    logic [W-1:0]   enq_data;
    logic           enq_last;

    beat_t        exp_q[$];
    logic [W-1:0] log_q[$];
    int           tests = 0;
    int           fails = 0;
    bit           run = 1'b0;

    fetch_block_unpacker #(.N_SLOTS(N), .ENTRY_WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_mask  (blk_mask),
        .enq_valid (enq_valid),
        .enq_ready (enq_ready),
        .enq_data  (enq_data),
        .enq_last  (enq_last)
    );

    always #5 clk = ~clk;

    // Monitor: compare outputs against the scoreboard mid-cycle.
    always @(negedge clk) begin
        if (run) begin
            logic exp_v;
            logic exp_r;
            exp_v = ~rst & ~flush & (exp_q.size() > 0);
            exp_r = ~rst & ~flush &
                    ((exp_q.size() == 0) | (exp_v & enq_ready & exp_q[0].last));
            tests++;
            if (enq_valid !== exp_v) begin
                fails++;
                $display("FAIL enq_valid t=%0t got %b exp %b", $time, enq_valid, exp_v);
            end
            tests++;
            if (blk_ready !== exp_r) begin
                fails++;
                $display("FAIL blk_ready t=%0t got %b exp %b", $time, blk_ready, exp_r);
            end
            if (exp_v) begin
                tests++;
                if (enq_data !== exp_q[0].data || enq_last !== exp_q[0].last) begin
                    fails++;
                    $display("FAIL enq_beat t=%0t got %h/%b exp %h/%b", $time,
                             enq_data, enq_last, exp_q[0].data, exp_q[0].last);
                end
                if (enq_ready) begin
                    log_q.push_back(enq_data);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // One cycle of stimulus; after the monitor, apply accept/flush to the model.
    task automatic cyc(input logic r, input logic bv, input logic [N-1:0] m,
                       input logic [N*W-1:0] d, input logic er, input logic fl);
        rst       = r;
        blk_valid = bv;
        blk_mask  = m;
        blk_data  = d;
        enq_ready = er;
        flush     = fl;
        @(negedge clk);
        #1;
        if (r || fl) begin
            exp_q.delete();
        end else if (bv && exp_q.size() == 0) begin
            for (int i = 0; i < N; i++) begin
                if (m[i]) begin
                    beat_t b;
                    b.data = d[i*W +: W];
                    b.last = ((m >> (i + 1)) == '0);
                    exp_q.push_back(b);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_log(input string name, input int n,
                              input logic [W-1:0] e0, input logic [W-1:0] e1,
                              input logic [W-1:0] e2, input logic [W-1:0] e3);
        logic [W-1:0] e[4];
        e = '{e0, e1, e2, e3};
        tests++;
        if (log_q.size() != n) begin
            fails++;
            $display("FAIL %s beats got %0d exp %0d", name, log_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                tests++;
                if (log_q[i] !== e[i]) begin
                    fails++;
                    $display("FAIL %s beat%0d got %h exp %h", name, i, log_q[i], e[i]);
                end
            end
        end
        log_q.delete();
    endtask

    localparam logic [W-1:0] D0 = 32'hD000_0000;
    localparam logic [W-1:0] D1 = 32'hD111_1111;
    localparam logic [W-1:0] D2 = 32'hD222_2222;
    localparam logic [W-1:0] D3 = 32'hD333_3333;
    localparam logic [W-1:0] A0 = 32'hA000_00A0;
    localparam logic [W-1:0] A2 = 32'hA222_22A2;
    localparam logic [W-1:0] B3 = 32'hB333_33B3;

    initial begin
        logic [N*W-1:0] dd;
        logic [N*W-1:0] da;
        logic [N*W-1:0] db;
        dd = {D3, D2, D1, D0};
        da = {32'hEEEE_EEE3, A2, 32'hEEEE_EEE1, A0};
        db = {B3, 32'hBBBB_0002, 32'hBBBB_0001, 32'hBBBB_0000};
        rst = 1'b1; flush = 1'b0; blk_valid = 1'b0; blk_mask = '0;
        blk_data = '0; enq_ready = 1'b0;
        @(posedge clk);
        #1;
        run = 1'b1;

        // reset held with a block offered
        repeat (3) cyc(1, 1, 4'b1111, dd, 1, 0);
        cyc(0, 0, 4'b0000, '0, 1, 0);
        log_q.delete();

        // full block, free-flowing fifo
        cyc(0, 1, 4'b1111, dd, 1, 0);
        repeat (5) cyc(0, 0, 4'b0000, '0, 1, 0);
        expect_log("full", 4, D0, D1, D2, D3);

        // back-to-back blocks, B accepted on A's last beat
        cyc(0, 1, 4'b0101, da, 1, 0);
        cyc(0, 1, 4'b1000, db, 1, 0);
        cyc(0, 1, 4'b1000, db, 1, 0);
        cyc(0, 0, 4'b0000, '0, 1, 0);
        cyc(0, 0, 4'b0000, '0, 1, 0);
        expect_log("b2b", 3, A0, A2, B3, '0);

        // backpressure
        cyc(0, 1, 4'b0011, dd, 0, 0);
        repeat (5) cyc(0, 0, 4'b0000, '0, 0, 0);
        expect_log("stall", 0, '0, '0, '0, '0);
        repeat (3) cyc(0, 0, 4'b0000, '0, 1, 0);
        expect_log("release", 2, D0, D1, '0, '0);

        // flush after D1, then an empty-mask block
        cyc(0, 1, 4'b1111, dd, 1, 0);
        cyc(0, 0, 4'b0000, '0, 1, 0);
        cyc(0, 0, 4'b0000, '0, 1, 0);
        cyc(0, 1, 4'b1111, dd, 1, 1);
        repeat (3) cyc(0, 0, 4'b0000, '0, 1, 0);
        expect_log("flush", 2, D0, D1, '0, '0);
        cyc(0, 1, 4'b0000, dd, 1, 0);
        repeat (2) cyc(0, 0, 4'b0000, '0, 1, 0);
        expect_log("zmask", 0, '0, '0, '0, '0);

        // reset mid-drain loses the rest
        cyc(0, 1, 4'b1111, dd, 0, 0);
        cyc(1, 0, 4'b0000, '0, 1, 0);
        repeat (2) cyc(0, 0, 4'b0000, '0, 1, 0);
        expect_log("rst_mid", 0, '0, '0, '0, '0);

        // random traffic against the scoreboard
        for (int c = 0; c < 10000; c++) begin
            logic [N*W-1:0] rd;
            for (int i = 0; i < N; i++) rd[i*W +: W] = $urandom;
            cyc(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rd,
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) < 2));
        end
        log_q.delete();

        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
